// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: fixed/round-robin arbiter with bounded bus locking, N word accessors onto one memory port
//   clock, reset                 : clock, synchronous active-high reset
//   memory_*                     : single shared memory port (enable/operation/ready/byte_mask/word_address/data)
//   accessor_memory_*            : flat per-accessor request buses; data_in is broadcast, ready goes to the granted one
//   accessor_grant               : one-hot current owner, zero while idle
module memory_arbiter_rr #(
  parameter int SIZE = 32,
  parameter int ACCESSOR_COUNT = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int LOCK_TIMEOUT = 16,
  localparam int SIZE_BYTES = SIZE / 8,
  localparam int WADDR = SIZE - $clog2(SIZE_BYTES)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  output logic                                   memory_enable,
  output logic                                   memory_operation,
  input  logic                                   memory_ready,
  output logic [SIZE_BYTES-1:0]                  memory_byte_mask,
  output logic [WADDR-1:0]                       memory_word_address,
  input  logic [SIZE-1:0]                        memory_data_in,
  output logic [SIZE-1:0]                        memory_data_out,
  input  logic [ACCESSOR_COUNT-1:0]              accessor_memory_enable,
  input  logic [ACCESSOR_COUNT-1:0]              accessor_memory_operation,
  input  logic [ACCESSOR_COUNT-1:0]              accessor_memory_lock,
  output logic [ACCESSOR_COUNT-1:0]              accessor_memory_ready,
  input  logic [ACCESSOR_COUNT*SIZE_BYTES-1:0]   accessor_memory_byte_mask,
  input  logic [ACCESSOR_COUNT*WADDR-1:0]        accessor_memory_word_address,
  output logic [ACCESSOR_COUNT*SIZE-1:0]         accessor_memory_data_in,
  input  logic [ACCESSOR_COUNT*SIZE-1:0]         accessor_memory_data_out,
  output logic [ACCESSOR_COUNT-1:0]              accessor_grant
);
  localparam int N = ACCESSOR_COUNT;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LOCK_TIMEOUT == 0 ? 0 : LOCK_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, LOCKED} state_t;
  state_t state, state_n;
  logic [IW-1:0] g, g_n, rr_ptr, rr_n, w, next_ptr;
  logic [CW-1:0] lock_cnt, lock_cnt_n;
  logic done;
  int idx;
  assign next_ptr = g == LAST_IDX ? '0 : g + IW'(1);
  assign done = !accessor_memory_enable[g] && !memory_ready;
  // Scan from the highest offset down so the lowest offset from the search start is the final winner.
  always_comb begin
    w = '0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (ROUND_ROBIN != 0) ? int'(rr_ptr) + i : i;
      idx = idx >= N ? idx - N : idx;
      if (accessor_memory_enable[idx]) w = IW'(idx);
    end
  end
  always_comb begin
    state_n = state;
    g_n = g;
    rr_n = rr_ptr;
    lock_cnt_n = lock_cnt;
    case (state)
      IDLE: if (|accessor_memory_enable) begin
        state_n = ACTIVE;
        g_n = w;
      end
      ACTIVE: if (done) begin
        if (accessor_memory_lock[g] && LOCK_TIMEOUT != 0) begin
          state_n = LOCKED;
          lock_cnt_n = '0;
        end else begin
          state_n = IDLE;
          rr_n = next_ptr;
        end
      end
      LOCKED: if (accessor_memory_enable[g]) state_n = ACTIVE;
        else if (!accessor_memory_lock[g] || lock_cnt == LAST_CNT) begin
          state_n = IDLE;
          rr_n = next_ptr;
        end else lock_cnt_n = lock_cnt + CW'(1);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= '0;
      lock_cnt <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      rr_ptr <= rr_n;
      lock_cnt <= lock_cnt_n;
    end
  end
  assign memory_enable = state == ACTIVE && accessor_memory_enable[g];
  assign memory_operation = accessor_memory_operation[g];
  assign memory_byte_mask = accessor_memory_byte_mask[g*SIZE_BYTES +: SIZE_BYTES];
  assign memory_word_address = accessor_memory_word_address[g*WADDR +: WADDR];
  assign memory_data_out = accessor_memory_data_out[g*SIZE +: SIZE];
  assign accessor_memory_data_in = {N{memory_data_in}};
  assign accessor_memory_ready = (state == ACTIVE && memory_ready) ? N'(1) << g : '0;
  assign accessor_grant = state != IDLE ? N'(1) << g : '0;
endmodule

// File: tb/tb_memory_arbiter_rr.sv
// tb_memory_arbiter_rr: directed checks of round-robin, fixed priority, locking, lock timeout and reset abort
module tb_memory_arbiter_rr;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic me_a, mop_a, mrdy_a, me_b, mop_b, mrdy_b, mem_hold;
  logic [3:0] mmask_a, mmask_b;
  logic [29:0] maddr_a, maddr_b;
  logic [31:0] mdin_a, mdout_a, mdout_b;
  logic [2:0] en_a, lk_a, rdy_a, gr_a;
  logic [1:0] en_b, rdy_b, gr_b;
  logic [89:0] wa_a;
  logic [95:0] din_a, dout_a;
  logic [63:0] din_b;
  logic [29:0] addr_a [3];
  int want_a [3], gap_a [3], want_b [2], gap_b [2];
  int log_idx [$], log_b [$];
  logic [29:0] log_addr [$];
  logic log_op [$];
  logic [31:0] log_dat [$];
  logic [3:0] log_msk [$];
  logic me_snap;
  logic [2:0] gr_snap;
  int n_checks = 0, n_fail = 0, n;
  assign wa_a = {addr_a[2], addr_a[1], addr_a[0]};
  assign dout_a = {2'b10, addr_a[2], 2'b10, addr_a[1], 2'b10, addr_a[0]};
  memory_arbiter_rr #(.SIZE(32), .ACCESSOR_COUNT(3), .ROUND_ROBIN(1), .LOCK_TIMEOUT(4)) dut_a (
    .clock(clock), .reset(reset),
    .memory_enable(me_a), .memory_operation(mop_a), .memory_ready(mrdy_a),
    .memory_byte_mask(mmask_a), .memory_word_address(maddr_a),
    .memory_data_in(mdin_a), .memory_data_out(mdout_a),
    .accessor_memory_enable(en_a), .accessor_memory_operation(3'b010),
    .accessor_memory_lock(lk_a), .accessor_memory_ready(rdy_a),
    .accessor_memory_byte_mask(12'h321), .accessor_memory_word_address(wa_a),
    .accessor_memory_data_in(din_a), .accessor_memory_data_out(dout_a),
    .accessor_grant(gr_a));
  memory_arbiter_rr #(.SIZE(32), .ACCESSOR_COUNT(2), .ROUND_ROBIN(0), .LOCK_TIMEOUT(4)) dut_b (
    .clock(clock), .reset(reset),
    .memory_enable(me_b), .memory_operation(mop_b), .memory_ready(mrdy_b),
    .memory_byte_mask(mmask_b), .memory_word_address(maddr_b),
    .memory_data_in(32'h0), .memory_data_out(mdout_b),
    .accessor_memory_enable(en_b), .accessor_memory_operation(2'b00),
    .accessor_memory_lock(2'b00), .accessor_memory_ready(rdy_b),
    .accessor_memory_byte_mask(8'hFF), .accessor_memory_word_address(60'h0),
    .accessor_memory_data_in(din_b), .accessor_memory_data_out(64'h0),
    .accessor_grant(gr_b));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: memory acks whatever is enabled, then each accessor completes, rests, or issues its next request.
  task automatic tick();
    @(posedge clock);
    #1;
    me_snap = me_a;
    gr_snap = gr_a;
    mrdy_a = me_a && !mem_hold;
    mrdy_b = me_b;
    #1;
    for (int i = 0; i < 3; i++)
      if (en_a[i] && rdy_a[i]) begin
        check("rdy_route", rdy_a, 128'(1) << i);
        log_idx.push_back(i);
        log_addr.push_back(maddr_a);
        log_op.push_back(mop_a);
        log_dat.push_back(mdout_a);
        log_msk.push_back(mmask_a);
        en_a[i] = 1'b0;
        gap_a[i] = 1;
        addr_a[i] = addr_a[i] + 30'd1;
      end else if (!en_a[i] && gap_a[i] > 0) gap_a[i]--;
      else if (!en_a[i] && want_a[i] > 0) begin
        en_a[i] = 1'b1;
        want_a[i]--;
      end
    for (int i = 0; i < 2; i++)
      if (en_b[i] && rdy_b[i]) begin
        log_b.push_back(i);
        en_b[i] = 1'b0;
        gap_b[i] = 1;
      end else if (!en_b[i] && gap_b[i] > 0) gap_b[i]--;
      else if (!en_b[i] && want_b[i] > 0) begin
        en_b[i] = 1'b1;
        want_b[i]--;
      end
  endtask
  task automatic wait_logs(input int na, input int nb);
    for (int t = 0; t < 300 && (log_idx.size() < na || log_b.size() < nb); t++) tick();
    check("log_len_a", log_idx.size(), na);
    check("log_len_b", log_b.size(), nb);
  endtask
  task automatic clear_logs();
    repeat (4) tick();
    log_idx.delete(); log_addr.delete(); log_op.delete(); log_dat.delete(); log_msk.delete(); log_b.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int exp_a [6] = '{0, 1, 0, 1, 0, 1};
    int exp_b [6] = '{0, 0, 0, 1, 1, 1};
    en_a = '0; lk_a = '0; en_b = '0; mrdy_a = 1'b0; mrdy_b = 1'b0; mem_hold = 1'b0;
    mdin_a = 32'hCAFE_F00D;
    addr_a = '{30'h100, 30'h200, 30'h3F0};
    want_a = '{0, 0, 0}; gap_a = '{0, 0, 0}; want_b = '{0, 0}; gap_b = '{0, 0};
    repeat (3) tick();
    check("rst_en", me_a, 1'b0);
    check("rst_grant", gr_a, 3'b000);
    check("rst_ready", rdy_a, 3'b000);
    check("bcast", din_a, {3{32'hCAFE_F00D}});
    reset = 1'b0;
    want_a[0] = 3; want_a[1] = 3; want_b[0] = 3; want_b[1] = 3;
    tick();
    tick();
    check("lat_en", me_snap, 1'b1);
    check("lat_grant", gr_snap, 3'b001);
    wait_logs(6, 6);
    for (int i = 0; i < 6; i++) check($sformatf("rr_%0d", i), log_idx[i], exp_a[i]);
    for (int i = 0; i < 6; i++) check($sformatf("fixed_%0d", i), log_b[i], exp_b[i]);
    check("rr_addr0", log_addr[0], 30'h100);
    check("rr_addr1", log_addr[1], 30'h200);
    check("rr_mask0", log_msk[0], 4'h1);
    check("rr_op0", log_op[0], 1'b0);
    clear_logs();
    lk_a = 3'b010;
    addr_a[0] = 30'h300;
    addr_a[1] = 30'h10;
    want_a[1] = 3;
    tick();
    want_a[0] = 1;
    wait_logs(3, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (gr_snap != 3'b000 && n < 30);
    check("lock_timeout_len", n, 6);
    tick();
    check("after_timeout_grant", gr_snap, 3'b001);
    wait_logs(4, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lock_idx_%0d", i), log_idx[i], 1);
      check($sformatf("lock_addr_%0d", i), log_addr[i], 30'h10 + 30'(i));
      check($sformatf("lock_op_%0d", i), log_op[i], 1'b1);
    end
    check("lock_data0", log_dat[0], 32'h8000_0010);
    check("lock_mask0", log_msk[0], 4'h2);
    check("lock_then_acc0", log_idx[3], 0);
    check("acc0_addr", log_addr[3], 30'h300);
    clear_logs();
    want_a[1] = 1;
    wait_logs(1, 0);
    tick();
    tick();
    check("locked_grant", gr_snap, 3'b010);
    check("locked_en", me_snap, 1'b0);
    lk_a = 3'b000;
    tick();
    check("release_grant", gr_snap, 3'b000);
    clear_logs();
    want_a[0] = 1; want_a[2] = 1;
    wait_logs(2, 0);
    check("wrap_first", log_idx[0], 2);
    check("wrap_second", log_idx[1], 0);
    check("wrap_addr", log_addr[0], 30'h3F0);
    clear_logs();
    mem_hold = 1'b1;
    want_a[0] = 1;
    tick();
    tick();
    check("hold_en", me_snap, 1'b1);
    check("hold_grant", gr_snap, 3'b001);
    reset = 1'b1;
    tick();
    check("abort_en", me_snap, 1'b0);
    check("abort_grant", gr_snap, 3'b000);
    check("abort_ready", rdy_a, 3'b000);
    en_a = '0;
    mem_hold = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    check("post_abort_idle", gr_snap, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
